// File: rtl/ram_port_arbiter.sv
// Shares the single RAM port between instruction fetch and load/store, one transaction at a time.
// Build option RAM_ARB_TIMEOUT_EN: abort a BUSY access after TIMEOUT_CYCLES edges without MFC.
module ram_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        Clk,
    input  logic        RESET,
    input  logic        if_req,
    input  logic [8:0]  if_addr,
    output logic        if_gnt,
    output logic        if_done,
    output logic [31:0] if_rdata,
    output logic        if_misalign,
    input  logic        ls_req,
    input  logic [5:0]  ls_op3,
    input  logic [8:0]  ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    output logic        ls_misalign,
    output logic        RAM_enable,
    output logic [5:0]  RAM_OpCode,
    output logic [8:0]  ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        MFC,
    output logic        timeout_err
);
    // Handshake: a requester raises *_req (level) with address/op/data stable at the sampling
    // edge and holds it until its one-cycle *_done; rdata and flags are meaningful only during done.
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS, RESP} state_t;

    state_t      state_q, state_d;
    logic        last_ls_q, last_ls_d;
    logic        owner_ls_q, owner_ls_d;
    logic [5:0]  op_q, op_d;
    logic [8:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
    logic        if_mis_q, if_mis_d, ls_mis_q, ls_mis_d;
    logic        tmo_q, tmo_d;
    logic        pick_ls, ls_mis_now, if_mis_now;
    logic        resp_now, resp_mis, resp_tmo;
    logic [31:0] resp_data;
`ifdef RAM_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0]  cnt_q, cnt_d;
`endif

    always_comb begin
        // last_ls_q=0 after reset, so LS wins the first tie.
        pick_ls    = ls_req && (!if_req || !last_ls_q);
        if_mis_now = (if_addr[1:0] != 2'b00);
        case (ls_op3[1:0])
            2'b00:   ls_mis_now = (ls_addr[1:0] != 2'b00);
            2'b10:   ls_mis_now = ls_addr[0];
            default: ls_mis_now = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        last_ls_d  = last_ls_q;
        owner_ls_d = owner_ls_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        resp_now   = 1'b0;
        resp_mis   = 1'b0;
        resp_tmo   = 1'b0;
        resp_data  = 32'h0;
`ifdef RAM_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef RAM_ARB_TIMEOUT_EN
                cnt_d = 8'd0;
`endif
                if (ls_req || if_req) begin
                    owner_ls_d = pick_ls;
                    if (pick_ls ? ls_mis_now : if_mis_now) begin
                        state_d  = RESP;
                        resp_now = 1'b1;
                        resp_mis = 1'b1;
                    end else begin
                        state_d = pick_ls ? BUSY_LS : BUSY_IF;
                        op_d    = pick_ls ? ls_op3 : 6'b000000;
                        addr_d  = pick_ls ? ls_addr : if_addr;
                        wdata_d = pick_ls ? ls_wdata : 32'h0;
                    end
                end
            end
            BUSY_IF, BUSY_LS: begin
                if (MFC) begin
                    state_d  = RESP;
                    resp_now = 1'b1;
                    // op3 bit 2 marks the store opcodes; stores return zero.
                    resp_data = op_q[2] ? 32'h0 : ram_rdata;
                end
`ifdef RAM_ARB_TIMEOUT_EN
                else if (cnt_q + 8'd1 == TMO_LIMIT) begin
                    state_d  = RESP;
                    resp_now = 1'b1;
                    resp_tmo = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            RESP: begin
                state_d   = IDLE;
                last_ls_d = owner_ls_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        if_mis_d   = if_mis_q;
        ls_mis_d   = ls_mis_q;
        tmo_d      = tmo_q;
        if (resp_now) begin
            tmo_d = resp_tmo;
            if (owner_ls_d) begin
                ls_rdata_d = resp_data;
                ls_mis_d   = resp_mis;
            end else begin
                if_rdata_d = resp_data;
                if_mis_d   = resp_mis;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (RESET) begin
            state_q    <= IDLE;
            last_ls_q  <= 1'b0;
            owner_ls_q <= 1'b0;
            op_q       <= 6'b0;
            addr_q     <= 9'b0;
            wdata_q    <= 32'h0;
            if_rdata_q <= 32'h0;
            ls_rdata_q <= 32'h0;
            if_mis_q   <= 1'b0;
            ls_mis_q   <= 1'b0;
            tmo_q      <= 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
            cnt_q      <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            last_ls_q  <= last_ls_d;
            owner_ls_q <= owner_ls_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
            if_mis_q   <= if_mis_d;
            ls_mis_q   <= ls_mis_d;
            tmo_q      <= tmo_d;
`ifdef RAM_ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign if_gnt      = (state_q == BUSY_IF);
    assign ls_gnt      = (state_q == BUSY_LS);
    assign RAM_enable  = (state_q == BUSY_IF) || (state_q == BUSY_LS);
    assign if_done     = (state_q == RESP) && !owner_ls_q;
    assign ls_done     = (state_q == RESP) && owner_ls_q;
    assign if_rdata    = if_rdata_q;
    assign ls_rdata    = ls_rdata_q;
    assign if_misalign = if_mis_q;
    assign ls_misalign = ls_mis_q;
    assign RAM_OpCode  = op_q;
    assign ram_addr    = addr_q;
    assign ram_wdata   = wdata_q;
    assign timeout_err = tmo_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: vector table, contention/reset/timeout sequences, random traffic
// checked against a transaction-level model of alignment and read-data rules.
module tb_ram_port_arbiter;
    localparam int TMO = 4;
    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;

    logic        Clk = 1'b0;
    logic        RESET = 1'b1;
    logic        if_req = 1'b0, ls_req = 1'b0, MFC = 1'b0;
    logic [8:0]  if_addr = '0, ls_addr = '0;
    logic [5:0]  ls_op3 = '0;
    logic [31:0] ls_wdata = '0, ram_rdata = '0;
    logic        if_gnt, if_done, if_misalign, ls_gnt, ls_done, ls_misalign;
    logic        RAM_enable, timeout_err;
    logic [31:0] if_rdata, ls_rdata, ram_wdata;
    logic [5:0]  RAM_OpCode;
    logic [8:0]  ram_addr;

    ram_port_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .Clk(Clk), .RESET(RESET),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
        .if_rdata(if_rdata), .if_misalign(if_misalign),
        .ls_req(ls_req), .ls_op3(ls_op3), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_done(ls_done), .ls_rdata(ls_rdata), .ls_misalign(ls_misalign),
        .RAM_enable(RAM_enable), .RAM_OpCode(RAM_OpCode), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .MFC(MFC), .timeout_err(timeout_err)
    );

    // clock / reset
    always #5 Clk = ~Clk;

    task automatic do_reset(input int cycles);
        RESET = 1'b1;
        repeat (cycles) @(negedge Clk);
        RESET = 1'b0;
    endtask

    // scoreboard
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    bit          exp_mis_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // reference model
    function automatic int op_size(input logic [5:0] op);
        case (op)
            OP_LD, OP_ST:             return 4;
            OP_LDUH, OP_LDSH, OP_STH: return 2;
            default:                  return 1;
        endcase
    endfunction

    function automatic bit op_is_store(input logic [5:0] op);
        return (op == OP_ST) || (op == OP_STB) || (op == OP_STH);
    endfunction

    // driver: one transaction on one port, RAM answers with MFC after `delay` idle BUSY cycles
    task automatic run_txn(input string tag, input bit is_ls, input logic [5:0] op3,
                           input logic [8:0] addr, input logic [31:0] wdata,
                           input logic [31:0] ram_word, input int delay,
                           input bit exp_mis, input logic [31:0] exp_rdata);
        int          n, busy;
        bit          got, wrong_done, mis_act, m_exp;
        logic        tmo_act;
        logic [31:0] rd_act, r_exp;
        exp_q.push_back(exp_rdata);
        exp_mis_q.push_back(exp_mis);
        if (is_ls) begin
            ls_op3 = op3; ls_addr = addr; ls_wdata = wdata; ls_req = 1'b1;
        end else begin
            if_addr = addr; if_req = 1'b1;
        end
        ram_rdata = ram_word;
        n = 0; busy = 0; got = 0; wrong_done = 0;
        mis_act = 0; tmo_act = 0; rd_act = '0;
        while (!got && n < 300) begin
            @(negedge Clk);
            n++;
            if (RAM_enable) begin
                if (busy == 0) begin
                    check({tag, " opcode"}, 32'(RAM_OpCode), is_ls ? 32'(op3) : 32'h0);
                    check({tag, " addr"}, 32'(ram_addr), 32'(addr));
                    check({tag, " wdata"}, ram_wdata, is_ls ? wdata : 32'h0);
                    check({tag, " gnt"}, {30'b0, if_gnt, ls_gnt}, is_ls ? 32'h1 : 32'h2);
                end
                MFC = (busy == delay);
                busy++;
            end else begin
                MFC = 1'b0;
            end
            if (is_ls ? if_done : ls_done) wrong_done = 1;
            if (is_ls ? ls_done : if_done) begin
                got     = 1;
                rd_act  = is_ls ? ls_rdata : if_rdata;
                mis_act = is_ls ? ls_misalign : if_misalign;
                tmo_act = timeout_err;
            end
        end
        ls_req = 1'b0; if_req = 1'b0; MFC = 1'b0;
        r_exp = exp_q.pop_front();
        m_exp = exp_mis_q.pop_front();
        check({tag, " done_seen"}, 32'(got), 32'h1);
        check({tag, " rdata"}, rd_act, r_exp);
        check({tag, " misalign"}, 32'(mis_act), 32'(m_exp));
        check({tag, " timeout_err"}, 32'(tmo_act), 32'h0);
        check({tag, " latency"}, 32'(n), m_exp ? 32'd1 : 32'(delay + 2));
        check({tag, " enable_cycles"}, 32'(busy), m_exp ? 32'd0 : 32'(delay + 1));
        check({tag, " other_done"}, 32'(wrong_done), 32'h0);
        @(negedge Clk);
        check({tag, " done_pulse"}, {30'b0, if_done, ls_done}, 32'h0);
    endtask

    // both ports request continuously; record which port completes, in order (1 = LS)
    task automatic contend(input string tag, input int count, input bit first_ls);
        int n;
        bit both;
        bit order[$];
        ls_op3 = OP_LD; ls_addr = 9'd4; ls_wdata = 32'h0; if_addr = 9'd8;
        ram_rdata = 32'h1;
        ls_req = 1'b1; if_req = 1'b1;
        n = 0; both = 0;
        while (order.size() < count && n < 100) begin
            @(negedge Clk);
            n++;
            MFC = RAM_enable;
            if (ls_done && if_done) both = 1;
            if (ls_done) order.push_back(1'b1);
            else if (if_done) order.push_back(1'b0);
        end
        ls_req = 1'b0; if_req = 1'b0; MFC = 1'b0;
        check({tag, " completions"}, 32'(order.size()), 32'(count));
        check({tag, " double_done"}, 32'(both), 32'h0);
        for (int i = 0; i < count; i++) begin
            int act;
            act = (i < order.size()) ? int'(order[i]) : 2;
            check($sformatf("%s order[%0d]", tag, i), 32'(act), 32'(first_ls ^ i[0]));
        end
        @(negedge Clk);
    endtask

    typedef struct {
        bit          is_ls;
        logic [5:0]  op3;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [31:0] ram_word;
        int          delay;
        bit          exp_mis;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t       tbl[12];
    logic [5:0] ops[8];

    initial begin
        tbl[0]  = '{1'b1, OP_LD,   9'd32, 32'h0,    32'h00000009, 3, 1'b0, 32'h00000009};
        tbl[1]  = '{1'b1, OP_ST,   9'd32, 32'h9,    32'h0000DEAD, 1, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, OP_LDUH, 9'd33, 32'h0,    32'h11111111, 0, 1'b1, 32'h0};
        tbl[3]  = '{1'b1, OP_LD,   9'd34, 32'h0,    32'h22222222, 0, 1'b1, 32'h0};
        tbl[4]  = '{1'b1, OP_LDUB, 9'd33, 32'h0,    32'h000000AB, 0, 1'b0, 32'h000000AB};
        tbl[5]  = '{1'b0, OP_LD,   9'd64, 32'h0,    32'h12345678, 0, 1'b0, 32'h12345678};
        tbl[6]  = '{1'b0, OP_LD,   9'd66, 32'h0,    32'h33333333, 0, 1'b1, 32'h0};
        tbl[7]  = '{1'b1, OP_STH,  9'd34, 32'hABCD, 32'h44444444, 2, 1'b0, 32'h0};
        tbl[8]  = '{1'b1, OP_STB,  9'd35, 32'h5A,   32'h55555555, 0, 1'b0, 32'h0};
        tbl[9]  = '{1'b1, OP_LDSH, 9'd36, 32'h0,    32'hFFFF8000, 1, 1'b0, 32'hFFFF8000};
        tbl[10] = '{1'b1, OP_ST,   9'd37, 32'h1,    32'h66666666, 0, 1'b1, 32'h0};
        tbl[11] = '{1'b0, OP_LD,   9'd65, 32'h0,    32'h77777777, 0, 1'b1, 32'h0};
        ops = '{OP_LD, OP_LDUB, OP_LDUH, OP_LDSB, OP_LDSH, OP_ST, OP_STB, OP_STH};

        do_reset(3);
        check("reset flags", {24'b0, RAM_enable, if_gnt, ls_gnt, if_done, ls_done,
                              if_misalign, ls_misalign, timeout_err}, 32'h0);
        check("reset opcode", 32'(RAM_OpCode), 32'h0);
        check("reset addr", 32'(ram_addr), 32'h0);
        check("reset rdata", if_rdata | ls_rdata, 32'h0);

        contend("rr_reset", 4, 1'b1);

        for (int i = 0; i < 12; i++)
            run_txn($sformatf("vec%0d", i), tbl[i].is_ls, tbl[i].op3, tbl[i].addr, tbl[i].wdata,
                    tbl[i].ram_word, tbl[i].delay, tbl[i].exp_mis, tbl[i].exp_rdata);

        run_txn("pre_rr", 1'b1, OP_LD, 9'd12, 32'h0, 32'h0BADF00D, 0, 1'b0, 32'h0BADF00D);
        contend("rr_after_ls", 2, 1'b0);

        // reset during BUSY_LS
        run_txn("pre_rst", 1'b0, OP_LD, 9'd16, 32'h0, 32'hA5A5A5A5, 0, 1'b0, 32'hA5A5A5A5);
        begin
            int  n;
            bit  stray;
            ls_op3 = OP_LDUB; ls_addr = 9'd9; ls_wdata = 32'h77; ls_req = 1'b1;
            ram_rdata = 32'h5; MFC = 1'b0;
            n = 0;
            while (!RAM_enable && n < 20) begin
                @(negedge Clk);
                n++;
            end
            check("rst busy_reached", 32'(ls_gnt), 32'h1);
            RESET = 1'b1; ls_req = 1'b0;
            @(negedge Clk);
            check("rst flags", {24'b0, RAM_enable, if_gnt, ls_gnt, if_done, ls_done,
                                if_misalign, ls_misalign, timeout_err}, 32'h0);
            check("rst opcode", 32'(RAM_OpCode), 32'h0);
            check("rst addr", 32'(ram_addr), 32'h0);
            check("rst wdata", ram_wdata, 32'h0);
            check("rst if_rdata", if_rdata, 32'h0);
            check("rst ls_rdata", ls_rdata, 32'h0);
            RESET = 1'b0;
            stray = 0;
            repeat (5) begin
                @(negedge Clk);
                if (ls_done || RAM_enable) stray = 1;
            end
            check("rst no_done", 32'(stray), 32'h0);
            run_txn("post_rst", 1'b1, OP_LD, 9'd40, 32'h0, 32'h0000BEEF, 1, 1'b0, 32'h0000BEEF);
        end

        // random traffic against the model
        for (int i = 0; i < 40; i++) begin
            bit          is_ls, mis;
            logic [5:0]  op;
            logic [8:0]  addr;
            logic [31:0] wd, rw, er;
            int          sz;
            is_ls = 1'($urandom_range(0, 1));
            op    = is_ls ? ops[$urandom_range(0, 7)] : OP_LD;
            addr  = 9'($urandom_range(0, 511));
            wd    = $urandom;
            rw    = $urandom;
            sz    = is_ls ? op_size(op) : 4;
            mis   = (int'(addr) % sz) != 0;
            er    = (mis || (is_ls && op_is_store(op))) ? 32'h0 : rw;
            run_txn($sformatf("rnd%0d", i), is_ls, op, addr, wd, rw,
                    $urandom_range(0, 2), mis, er);
        end

`ifdef RAM_ARB_TIMEOUT_EN
        begin
            int  n;
            bit  got;
            ls_op3 = OP_LD; ls_addr = 9'd48; ls_req = 1'b1;
            ram_rdata = 32'hCAFEF00D; MFC = 1'b0;
            n = 0; got = 0;
            while (!got && n < 50) begin
                @(negedge Clk);
                n++;
                if (ls_done) begin
                    got = 1;
                    check("tmo timeout_err", 32'(timeout_err), 32'h1);
                    check("tmo rdata", ls_rdata, 32'h0);
                    check("tmo misalign", 32'(ls_misalign), 32'h0);
                end
            end
            ls_req = 1'b0;
            check("tmo done_seen", 32'(got), 32'h1);
            check("tmo latency", 32'(n), 32'(TMO + 1));
            @(negedge Clk);
            run_txn("tmo_mfc_tie", 1'b1, OP_LD, 9'd52, 32'h0, 32'h13579BDF, TMO - 1,
                    1'b0, 32'h13579BDF);
        end
`else
        begin
            bit left;
            ls_op3 = OP_LD; ls_addr = 9'd48; ls_req = 1'b1;
            ram_rdata = 32'hCAFEF00D; MFC = 1'b0;
            left = 0;
            repeat (100) begin
                @(negedge Clk);
                if (ls_done || timeout_err) left = 1;
            end
            check("no_tmo still_busy", {30'b0, ls_gnt, RAM_enable}, 32'h3);
            check("no_tmo no_done", 32'(left), 32'h0);
            MFC = 1'b1;
            @(negedge Clk);
            MFC = 1'b0;
            check("no_tmo done", 32'(ls_done), 32'h1);
            check("no_tmo rdata", ls_rdata, 32'hCAFEF00D);
            check("no_tmo timeout_err", 32'(timeout_err), 32'h0);
            ls_req = 1'b0;
            @(negedge Clk);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Shares the single RAM port between the instruction-fetch path and the load/store path of the SPARC V8 multicycle datapath. It sequences one RAM transaction at a time and drives `RAM_enable`/`RAM_OpCode`, address and write data. It waits for `MFC`, then returns the read data with a one-cycle done pulse. Misaligned accesses are rejected before reaching RAM so the control unit can raise the alignment trap (tt) without touching memory.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, 15: BUSY cycles without `MFC` before abort (timeout build only); legal range 1–255.

Ports:
- `Clk` input 1: single system clock, rising edge.
- `RESET` input 1: synchronous, active-high reset.
- `if_req` input 1: fetch request; level, held until `if_done`.
- `if_addr` input 9: fetch byte address.
- `if_gnt` output 1: fetch owns the port (BUSY_IF).
- `if_done` output 1: one-cycle completion pulse.
- `if_rdata` output 32: fetched word, valid during `if_done`.
- `if_misalign` output 1: valid with `if_done`; set when `if_addr[1:0]!=0`.
- `ls_req` input 1: load/store request; level, held until `ls_done`.
- `ls_op3` input 6: SPARC op3 (LD 000000, LDUB 000001, LDUH 000010, LDSB 001001, LDSH 001010, ST 000100, STB 000101, STH 000110).
- `ls_addr` input 9: data byte address.
- `ls_wdata` input 32: store data.
- `ls_gnt` output 1: load/store owns the port.
- `ls_done` output 1: one-cycle completion pulse.
- `ls_rdata` output 32: load result, valid during `ls_done`.
- `ls_misalign` output 1: valid with `ls_done`.
- `RAM_enable` output 1: RAM strobe.
- `RAM_OpCode` output 6: op3 presented to RAM.
- `ram_addr` output 9: RAM address.
- `ram_wdata` output 32: RAM write data.
- `ram_rdata` input 32: RAM read data; the RAM performs extension.
- `MFC` input 1: memory function complete.
- `timeout_err` output 1: valid with done; tied 0 when the timeout feature is compiled out.

## Operation

- States: IDLE, BUSY_IF, BUSY_LS, RESP.
- IDLE, at each edge:
  - Only `ls_req` high: go to BUSY_LS.
  - Only `if_req` high: go to BUSY_IF.
  - Both high: round-robin; the requester not granted last wins. The pointer favours LS after reset.
- Alignment is checked in IDLE, before any RAM access:
  - Size comes from op3[1:0]: 00 = word, 01 = byte, 10 = half.
  - Half is misaligned if addr[0]=1. Word is misaligned if addr[1:0]!=0. Fetch is always word-sized.
  - A misaligned winner goes straight to RESP with misalign=1. `RAM_enable` is never asserted and rdata is 0.
- Entering BUSY latches `ram_addr`, `RAM_OpCode` and `ram_wdata`. For fetch these are `if_addr`, op3=000000 and wdata 0.
- In BUSY:
  - `RAM_enable`=1 and the matching `*_gnt`=1.
  - `MFC`=1 at an edge: capture `ram_rdata` (stores capture 0), go to RESP.
- RESP, for one cycle:
  - The owner's `*_done`=1 and `RAM_enable`=0.
  - Flags and rdata are valid.
  - The round-robin pointer updates to the owner, then the FSM returns to IDLE.
- `rdata` and the flags hold until the next RESP. Consumers use them only during done.
- `MSET` is not used by this block.
- `RESET` overrides everything:
  - FSM to IDLE, pointer reset to favour LS.
  - All outputs 0, including `RAM_enable`, gnt, done, rdata, flags, `RAM_OpCode`, `ram_addr` and `ram_wdata`.
  - An in-flight access is abandoned with no done pulse.

## Timing

- Aligned access, edge numbering:
  - `req` high before edge 0: BUSY from edge 0.
  - `MFC` sampled high at edge k: RESP in cycle k→k+1.
  - IDLE from edge k+1.
- Minimum latency is 2 cycles from request to done, with `MFC` high on the first BUSY edge.
- A misaligned request gives done 1 cycle after the sampling edge.
- The requester must deassert `req` in the cycle after done. A `req` still high at the IDLE edge starts a new access.
- A requester not yet served simply stays high. It is served at the next IDLE, with at most one intervening access.
- Address, op3 and wdata only need to be stable at the sampling edge; they are latched.
- A request change during BUSY or RESP is ignored.

## Configuration

- `RAM_ARB_TIMEOUT_EN` defined:
  - An 8-bit counter clears on BUSY entry and increments each BUSY edge without `MFC`.
  - Reaching `TIMEOUT_CYCLES` aborts the access: RESP with `timeout_err`=1, rdata 0.
  - `MFC` and timeout on the same edge: `MFC` wins, `timeout_err`=0.
- Undefined:
  - The counter is absent and `timeout_err` is constant 0.
  - BUSY waits indefinitely for `MFC`.

## Test plan

- Load: ls LD addr 32, RAM returns 0x00000009 with `MFC` 3 cycles after enable → `RAM_OpCode`=000000, `ram_addr`=32, `ls_done` pulse with `ls_rdata`=9 one cycle after the `MFC` edge.
- Store: ST addr 32, wdata 0x00000009 → `RAM_OpCode`=000100, `ram_wdata`=9; `ls_done`, `ls_rdata`=0.
- Contention: `if_req` and `ls_req` both high after reset → LS served first, then IF; repeat with both high → IF first, then LS.
- Alignment: LDUH addr 33 and LD addr 34 → `ls_done` 1 cycle later with `ls_misalign`=1 and `RAM_enable` never high; LDUB addr 33 → normal access.
- Reset: `RESET` high during BUSY_LS → next cycle all outputs 0, no `ls_done`; a new request after reset is served normally.
- Timeout: with `RAM_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, `MFC` held 0 → done after 4 BUSY edges with `timeout_err`=1; without the macro, still BUSY after 100 cycles.
